// File: rtl/counter_cmd_seq_if.sv
// ============================================================================
// counter_cmd_seq_if : command handshake bus {op, data, dwell} for counter_cmd_seq
// Rev 1.0
// ============================================================================
`default_nettype none

interface counter_cmd_seq_if #(
   parameter int WIDTH   = 8,
   parameter int DWELL_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [WIDTH-1:0]   cmd_data;
   logic [DWELL_W-1:0] cmd_dwell;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      output cmd_dwell,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      input  cmd_dwell,
      output cmd_ready
   );
endinterface

`default_nettype wire

// File: rtl/counter_cmd_seq.sv
// ============================================================================
// counter_cmd_seq : sequences {op, data, dwell} commands into counter is_up/load/in
// controls; define COUNTER_CMD_FIFO_EN to insert a FIFO_DEPTH-entry command FIFO.
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_cmd_seq #(
   parameter int WIDTH      = 8,
   parameter int DWELL_W    = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst,
   counter_cmd_seq_if.slave      cmd,
   output logic                  is_up_o,
   output logic                  load_o,
   output logic [WIDTH-1:0]      in_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam logic [1:0] c_OP_LOAD = 2'b00;
   localparam logic [1:0] c_OP_UP   = 2'b01;
   localparam logic [1:0] c_OP_DOWN = 2'b10;

   localparam logic [0:0] c_S_IDLE  = 1'b0;
   localparam logic [0:0] c_S_EXEC  = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [DWELL_W-1:0] rem_q, rem_d;
   logic               is_up_q, is_up_d;
   logic               load_q, load_d;
   logic [WIDTH-1:0]   in_q, in_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               w_last;
   logic               w_can_start;
   logic               w_start;
   logic [1:0]         w_op;
   logic [WIDTH-1:0]   w_data;
   logic [DWELL_W-1:0] w_dwell;
   logic [DWELL_W-1:0] w_dwell_eff;

   assign w_last      = (state_q == c_S_EXEC) && (rem_q == DWELL_W'(1));
   assign w_can_start = (state_q == c_S_IDLE) || w_last;

`ifdef COUNTER_CMD_FIFO_EN
   localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int c_CNT_W   = c_PTR_W + 1;
   localparam int c_ENTRY_W = 2 + WIDTH + DWELL_W;

   logic [c_ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [c_PTR_W-1:0]   wr_ptr_q;
   logic [c_PTR_W-1:0]   rd_ptr_q;
   logic [c_CNT_W-1:0]   count_q;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_push;
   logic                 w_pop;

   assign w_full        = (count_q == c_CNT_W'(FIFO_DEPTH));
   assign w_empty       = (count_q == '0);
   assign cmd.cmd_ready = rst & ~w_full;
   assign w_push        = cmd.cmd_valid & cmd.cmd_ready;
   assign w_pop         = w_can_start & ~w_empty;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
         count_q <= count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_data, cmd.cmd_dwell};
      end
   end

   assign {w_op, w_data, w_dwell} = fifo_mem_q[rd_ptr_q];
   assign w_start = w_pop;
`else
   logic w_ready;

   assign w_ready       = rst & w_can_start;
   assign cmd.cmd_ready = w_ready;
   assign w_start       = cmd.cmd_valid & w_ready;
   assign w_op          = cmd.cmd_op;
   assign w_data        = cmd.cmd_data;
   assign w_dwell       = cmd.cmd_dwell;
`endif

   assign w_dwell_eff = (w_dwell == '0) ? DWELL_W'(1) : w_dwell;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= c_S_IDLE;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         c_S_IDLE: begin
            if (w_start) begin
               state_d = c_S_EXEC;
               rem_d   = w_dwell_eff;
            end
         end
         c_S_EXEC: begin
            if (w_start) begin
               rem_d = w_dwell_eff;
            end else if (w_last) begin
               state_d = c_S_IDLE;
               rem_d   = '0;
            end else begin
               rem_d = rem_q - DWELL_W'(1);
            end
         end
         default: begin
            state_d = c_S_IDLE;
            rem_d   = '0;
         end
      endcase
   end

   // Controls change only at command boundaries and otherwise hold.
   always_comb begin
      is_up_d = is_up_q;
      load_d  = load_q;
      in_d    = in_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (w_last) begin
         load_d = 1'b0;
         busy_d = 1'b0;
         done_d = 1'b1;
      end
      if (w_start) begin
         busy_d = 1'b1;
         load_d = (w_op == c_OP_LOAD);
         if (w_op == c_OP_LOAD) in_d    = w_data;
         if (w_op == c_OP_UP)   is_up_d = 1'b1;
         if (w_op == c_OP_DOWN) is_up_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         is_up_q <= 1'b0;
         load_q  <= 1'b0;
         in_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         is_up_q <= is_up_d;
         load_q  <= load_d;
         in_q    <= in_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign is_up_o = is_up_q;
   assign load_o  = load_q;
   assign in_o    = in_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

`default_nettype wire
